// File: rtl/data_unpack_pkg.sv
// Shared widths, count type and bit-order helpers for the 32->7 bit unpacker.
package data_unpack_pkg;

    localparam int IN_W  = 32;
    localparam int SYM_W = 7;
    localparam int BUF_W = 38;  // up to 6 residual bits plus one full word

    typedef logic [5:0] cnt_t;

    function automatic logic [IN_W-1:0] rev_word(input logic [IN_W-1:0] w);
        logic [IN_W-1:0] r;
        for (int i = 0; i < IN_W; i++) r[i] = w[IN_W-1-i];
        return r;
    endfunction

    function automatic logic [SYM_W-1:0] rev_sym(input logic [SYM_W-1:0] s);
        logic [SYM_W-1:0] r;
        for (int i = 0; i < SYM_W; i++) r[i] = s[SYM_W-1-i];
        return r;
    endfunction

endpackage

// File: rtl/data_unpack_bitbuf.sv
// Bit buffer with fill count: appends a word at the current fill level (or
// at 0 when restarting a packet), shifts out 7 bits, or flushes to empty.
module data_unpack_bitbuf
    import data_unpack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             append_i,
    input  logic             restart_i,
    input  logic             shift_i,
    input  logic             flush_i,
    input  logic [IN_W-1:0]  word_i,
    output logic [SYM_W-1:0] head_o,
    output cnt_t             cnt_o
);

    logic [BUF_W-1:0] bits_q, bits_d;
    cnt_t             cnt_q, cnt_d;
    cnt_t             base;
    logic [BUF_W-1:0] keep;

    // Next-state: bits above the fill level are masked off so stale residue
    // from an abandoned packet can never leak into the new stream.
    always_comb begin
        bits_d = bits_q;
        cnt_d  = cnt_q;
        base   = restart_i ? '0 : cnt_q;
        keep   = restart_i ? '0 : ((BUF_W'(1) << cnt_q) - BUF_W'(1));
        if (flush_i) begin
            bits_d = '0;
            cnt_d  = '0;
        end else if (append_i) begin
            bits_d = (bits_q & keep) | (BUF_W'(word_i) << base);
            cnt_d  = base + cnt_t'(IN_W);
        end else if (shift_i) begin
            bits_d = bits_q >> SYM_W;
            cnt_d  = cnt_q - cnt_t'(SYM_W);
        end
    end

    // Buffer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bits_q <= '0;
            cnt_q  <= '0;
        end else begin
            bits_q <= bits_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o = bits_q[SYM_W-1:0];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/data_unpack_7b.sv
// Packetised 32-bit word stream to 7-bit symbol stream, zero-padding the
// final partial symbol. Define DATA_UNPACK_MSB_FIRST_EN for MSB-first bit
// order (data_in[31] first, symbol MSB earliest, pad in the LSBs).
module data_unpack_7b
    import data_unpack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             sop_in,
    input  logic             eop_in,
    input  logic [IN_W-1:0]  data_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic             sop_out,
    output logic             eop_out,
    output logic [SYM_W-1:0] data_out
);

    cnt_t             cnt;
    logic [SYM_W-1:0] head;
    logic [IN_W-1:0]  word;
    logic             in_pkt_q, in_pkt_d;
    logic             sop_pend_q, sop_pend_d;
    logic             eop_pend_q, eop_pend_d;
    logic             valid_q, sop_q, eop_q;
    logic [SYM_W-1:0] data_q, sym;
    logic             accept, emit_full, emit_pad, emit, eop_emit, eop_idle;

`ifdef DATA_UNPACK_MSB_FIRST_EN
    // Reverse on the way in and out so the buffer always runs LSB-first.
    assign word = rev_word(data_in);
`else
    assign word = data_in;
`endif

    assign ready_out = (cnt <= cnt_t'(6)) && !eop_pend_q;
    assign accept    = valid_in && ready_out;

    // Emission decision and symbol formation from current state only.
    always_comb begin
        logic [SYM_W-1:0] raw;
        emit_full = (cnt >= cnt_t'(SYM_W));
        emit_pad  = !emit_full && eop_pend_q && (cnt != '0);
        emit      = emit_full || emit_pad;
        eop_emit  = emit && eop_pend_q && (cnt <= cnt_t'(SYM_W));
        eop_idle  = eop_pend_q && (cnt == '0);
        raw       = emit_full ? head
                              : (head & SYM_W'((8'(1) << cnt) - 8'(1)));
`ifdef DATA_UNPACK_MSB_FIRST_EN
        sym = rev_sym(raw);
`else
        sym = raw;
`endif
    end

    data_unpack_bitbuf u_bitbuf (
        .clk      (clk),
        .rst      (rst),
        .append_i (accept && (sop_in || in_pkt_q)),
        .restart_i(sop_in),
        .shift_i  (emit_full && !eop_emit),
        .flush_i  (eop_emit || eop_idle),
        .word_i   (word),
        .head_o   (head),
        .cnt_o    (cnt)
    );

    // Packet flags; accept and emission are mutually exclusive by construction.
    always_comb begin
        in_pkt_d   = in_pkt_q;
        sop_pend_d = sop_pend_q;
        eop_pend_d = eop_pend_q;
        if (accept) begin
            in_pkt_d = (sop_in || in_pkt_q) && !eop_in;
            if (sop_in) sop_pend_d = 1'b1;
            if (eop_in) eop_pend_d = 1'b1;
        end else begin
            if (emit)                 sop_pend_d = 1'b0;
            if (eop_emit || eop_idle) eop_pend_d = 1'b0;
        end
    end

    // Flag and output registers; data_out holds its value on idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_pkt_q   <= 1'b0;
            sop_pend_q <= 1'b0;
            eop_pend_q <= 1'b0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            in_pkt_q   <= in_pkt_d;
            sop_pend_q <= sop_pend_d;
            eop_pend_q <= eop_pend_d;
            valid_q    <= emit;
            sop_q      <= emit && sop_pend_q;
            eop_q      <= eop_emit;
            if (emit) data_q <= sym;
        end
    end

    assign valid_out = valid_q;
    assign sop_out   = sop_q;
    assign eop_out   = eop_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_data_unpack_7b.sv
// Scoreboard bench for data_unpack_7b: a bit-queue reference model predicts
// symbols at accept time; a negedge monitor pops and compares each output.
module tb_data_unpack_7b;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, sop_in, eop_in;
    logic [31:0] data_in;
    logic        ready_out, valid_out, sop_out, eop_out;
    logic [6:0]  data_out;

    always #5 clk = ~clk;

    data_unpack_7b dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .sop_in(sop_in),
        .eop_in(eop_in), .data_in(data_in), .ready_out(ready_out),
        .valid_out(valid_out), .sop_out(sop_out), .eop_out(eop_out),
        .data_out(data_out)
    );

    typedef struct { logic [6:0] d; bit s; bit e; } exp_t;
    exp_t exp_q[$];
    bit   bq[$];
    bit   m_in_pkt, m_sop;
    int   checks = 0, errors = 0, mon_checks = 0, mon_errors = 0, n_sym = 0;

    // Reference: stream bits into a queue, cut 7-bit symbols, pad at packet end.
    function automatic void model_accept(bit s, bit e, logic [31:0] d);
        exp_t x;
        int   k;
        bit   b;
        if (s) begin bq.delete(); m_in_pkt = 1; m_sop = 1; end
        if (!m_in_pkt) return;
        for (int i = 0; i < 32; i++) begin
`ifdef DATA_UNPACK_MSB_FIRST_EN
            bq.push_back(d[31-i]);
`else
            bq.push_back(d[i]);
`endif
        end
        while (bq.size() >= 7 || (e && bq.size() > 0)) begin
            x.d = '0;
            k = 0;
            while (k < 7 && bq.size() > 0) begin
                b = bq.pop_front();
`ifdef DATA_UNPACK_MSB_FIRST_EN
                x.d[6-k] = b;
`else
                x.d[k] = b;
`endif
                k++;
            end
            x.s = m_sop;
            m_sop = 0;
            x.e = e && (bq.size() == 0);
            exp_q.push_back(x);
        end
        if (e) m_in_pkt = 0;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Offer a word until accepted (bounded); leaves valid_in high afterwards.
    task automatic send(bit s, bit e, logic [31:0] d);
        int t = 0;
        @(negedge clk);
        valid_in = 1; sop_in = s; eop_in = e; data_in = d;
        while (!ready_out && t < 200) begin @(negedge clk); t++; end
        if (!ready_out) begin
            checks++; errors++;
            $display("FAIL send_timeout got=ready_low exp=ready_high");
            valid_in = 0;
        end else begin
            model_accept(s, e, d);
            @(posedge clk);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in = 0; sop_in = 0; eop_in = 0;
        end
    endtask

    task automatic drain(string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin @(negedge clk); t++; end
        idle(2);
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: compare every presented symbol against the scoreboard head.
    always @(negedge clk) begin
        exp_t x;
        if (rst && valid_out) begin
            n_sym++;
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_errors++;
                $display("FAIL unexpected_sym got=%h/s%0d/e%0d exp=none",
                         data_out, sop_out, eop_out);
            end else begin
                x = exp_q.pop_front();
                if (data_out !== x.d || sop_out !== x.s || eop_out !== x.e) begin
                    mon_errors++;
                    $display("FAIL sym got=%h/s%0d/e%0d exp=%h/s%0d/e%0d",
                             data_out, sop_out, eop_out, x.d, x.s, x.e);
                end
            end
        end else if (rst && (sop_out || eop_out)) begin
            mon_checks++;
            mon_errors++;
            $display("FAIL flag_without_valid got=s%0d/e%0d exp=s0/e0",
                     sop_out, eop_out);
        end
    end

    initial begin
        int t, base;
        rst = 0; valid_in = 0; sop_in = 0; eop_in = 0; data_in = '0;
        #3;
        chk("rst_valid", valid_out, 0);
        chk("rst_sop", sop_out, 0);
        chk("rst_eop", eop_out, 0);
        chk("rst_data", data_out, 0);
        @(negedge clk); rst = 1;
        @(negedge clk);
        chk("rst_ready", ready_out, 1);

        // Single word, sop+eop: 5 symbols, ready low through the pad emission.
        send(1, 1, 32'h76543210);
        t = 0;
        @(negedge clk); valid_in = 0;
        while (!ready_out && t < 50) begin t++; @(negedge clk); end
        chk("single_ready_low_cycles", t, 5);
        drain("single_drain");

        // Two-word packet: zeros then ones, one padded residual bit.
        send(1, 0, 32'h00000000);
        send(0, 1, 32'hFFFFFFFF);
        idle(1);
        drain("two_word_drain");

        // Seven words back-to-back: 224 bits -> exactly 32 symbols, no pad.
        base = n_sym;
        for (int w = 0; w < 7; w++) send(w == 0, w == 6, $urandom);
        idle(1);
        drain("b2b_drain");
        chk("b2b_count", n_sym - base, 32);

        // Stray word outside a packet is swallowed silently.
        base = n_sym;
        send(0, 0, 32'hDEADBEEF);
        idle(12);
        chk("stray_no_output", n_sym - base, 0);
        chk("stray_ready", ready_out, 1);

        // New sop mid-packet discards the 4 residual bits.
        send(1, 0, 32'h12345678);
        send(1, 1, 32'hA5A5A5A5);
        idle(1);
        drain("midsop_drain");

        // Asynchronous reset while symbols are streaming out.
        send(1, 1, 32'hCAFEF00D);
        idle(1);
        @(posedge clk); #1;
        rst = 0;
        exp_q.delete(); bq.delete(); m_in_pkt = 0; m_sop = 0;
        #1;
        chk("rst_mid_valid", valid_out, 0);
        @(negedge clk); rst = 1;
        @(negedge clk);
        chk("rst_mid_ready", ready_out, 1);

        // Randomised packets, gaps, strays and abandoned packets.
        for (int p = 0; p < 30; p++) begin
            int len;
            bit abandon;
            if ($urandom_range(0, 4) == 0) send(0, 0, $urandom);
            len = $urandom_range(1, 5);
            abandon = ($urandom_range(0, 5) == 0);
            for (int w = 0; w < len; w++)
                send(w == 0, (w == len - 1) && !abandon, $urandom);
            idle($urandom_range(0, 2));
        end
        send(1, 1, $urandom);
        idle(1);
        drain("random_drain");

        errors = errors + mon_errors;
        checks = checks + mon_checks;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
